// File: rtl/dmem_block_responder.sv
// Main-memory responder for dcache block refills and write-backs.
// Request/busywait handshake with fixed latency over an internal 128-bit block array.
module dmem_block_responder #(
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_address,
    input  logic [127:0] mem_writedata,
    output logic [127:0] mem_readdata,
    output logic         mem_busywait,
    output logic         protocol_error
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_reg, state_next;
    logic [7:0]    cnt_reg, cnt_next;
    logic          op_write_reg;
    logic [27:0]   addr_reg;
    logic [127:0]  wdata_reg;
    logic [127:0]  readdata_reg;
    logic          perr_reg;
    logic [127:0]  blocks [0:DEPTH-1];

    logic                 req;
    logic                 both;
    logic                 changed;
    logic                 latch_en;
    logic                 do_access;
    logic                 err_set;
    logic [ADDR_BITS-1:0] index;

    assign req   = mem_read ^ mem_write;
    assign both  = mem_read & mem_write;
    assign index = addr_reg[ADDR_BITS-1:0];

    // Any deviation from the accepted request while it is in flight is a requester bug.
    assign changed = (mem_address != addr_reg) || (mem_write != op_write_reg)
                   || (op_write_reg && (mem_writedata != wdata_reg));

    assign mem_busywait   = req && ((state_reg == IDLE) || (state_reg == BUSY));
    assign mem_readdata   = readdata_reg;
    assign protocol_error = perr_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch_en   = 1'b0;
        do_access  = 1'b0;
        err_set    = both;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    latch_en   = 1'b1;
                    cnt_next   = 8'(LATENCY - 1);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!req) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    if (changed) begin
                        err_set = 1'b1;
                    end
                    if (cnt_reg != 8'd0) begin
                        cnt_next = cnt_reg - 8'd1;
                    end else begin
                        do_access  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 8'd0;
            op_write_reg <= 1'b0;
            addr_reg     <= 28'd0;
            wdata_reg    <= 128'd0;
            readdata_reg <= 128'd0;
            perr_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (latch_en) begin
                op_write_reg <= mem_write;
                addr_reg     <= mem_address;
                wdata_reg    <= mem_writedata;
            end
            if (do_access && !op_write_reg) begin
                readdata_reg <= blocks[index];
            end
            if (err_set) begin
                perr_reg <= 1'b1;
            end
        end
    end

    // Backing store clears on reset, so it is held in registers rather than block RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                blocks[i] <= 128'd0;
            end
        end else if (do_access && op_write_reg) begin
            blocks[index] <= wdata_reg;
        end
    end
endmodule

// File: tb/tb_dmem_block_responder.sv
// Directed bench for dmem_block_responder: vector table plus multi-cycle corner sequences.
// Default parameters (ADDR_BITS=6, LATENCY=4), so every completed access is busy for 5 cycles.
module tb_dmem_block_responder;
    logic         clock;
    logic         reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic         protocol_error;

    dmem_block_responder dut (
        .clock          (clock),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .mem_busywait   (mem_busywait),
        .protocol_error (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wd;
        int           exp_busy;
        logic [127:0] exp_rd;
        logic         exp_perr;
    } vec_t;

    localparam logic [127:0] D = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] A = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] E = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] C = 128'h0C0C0C0C_A5A5A5A5_5A5A5A5A_C0C0C0C0;
    localparam logic [127:0] X = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;
    localparam logic [127:0] F = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    localparam logic [127:0] G = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;

    int   n_vec;
    int   n_err;
    int   busy;
    vec_t vecs [8];
    logic [31:0] word0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge: drives a request and counts busy cycles
    // sampled at falling edges; returns at the first falling edge with busywait low.
    task automatic access(input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [127:0] wd, output int n);
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = addr;
        mem_writedata = wd;
        n = 0;
        do begin
            @(negedge clock);
            if (mem_busywait) n++;
        end while (mem_busywait && n < 300);
    endtask

    task automatic go_idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_address = 28'd0;
        mem_writedata = 128'd0;

        vecs[0] = '{1'b1, 1'b0, 28'h0000005, 128'd0, 5, 128'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 28'h0000003, D,      5, 128'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 28'h0000003, 128'd0, 5, D,      1'b0};
        vecs[3] = '{1'b0, 1'b1, 28'h0000002, A,      5, D,      1'b0};
        vecs[4] = '{1'b1, 1'b0, 28'h0000042, 128'd0, 5, A,      1'b0};
        vecs[5] = '{1'b1, 1'b0, 28'hFFFFFC2, 128'd0, 5, A,      1'b0};
        vecs[6] = '{1'b0, 1'b1, 28'h0000004, E,      5, A,      1'b0};
        vecs[7] = '{1'b1, 1'b0, 28'h0000004, 128'd0, 5, E,      1'b0};

        #12;
        chk("reset_busywait", {127'd0, mem_busywait}, 128'd0);
        chk("reset_readdata", mem_readdata, 128'd0);
        chk("reset_perr", {127'd0, protocol_error}, 128'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, busy);
            $display("vec %0d rd=%0b wr=%0b addr=%h busy=%0d readdata=%h perr=%0b",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].addr, busy, mem_readdata, protocol_error);
            chk($sformatf("vec%0d_busy", i), 128'(busy), 128'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_readdata", i), mem_readdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_perr", i), {127'd0, protocol_error}, {127'd0, vecs[i].exp_perr});
            if (i == 2) begin
                word0 = mem_readdata[31:0];
                chk("vec2_word0", {96'd0, word0}, {96'd0, 32'hCAFEF00D});
            end
            @(posedge clock); #1;
            go_idle();
            @(posedge clock); #1;
        end

        // Read dropped in its second BUSY cycle.
        mem_read = 1'b1; mem_address = 28'h0000003;
        @(posedge clock); @(posedge clock); #1;
        mem_read = 1'b0;
        #1 chk("abort_busywait", {127'd0, mem_busywait}, 128'd0);
        @(posedge clock); #1;
        $display("seq abort_read perr=%0b readdata=%h", protocol_error, mem_readdata);
        chk("abort_perr", {127'd0, protocol_error}, 128'd1);
        chk("abort_readdata", mem_readdata, E);
        // Aborted write must leave block 7 untouched.
        mem_write = 1'b1; mem_address = 28'h0000007; mem_writedata = X;
        @(posedge clock); @(posedge clock); #1;
        mem_write = 1'b0;
        @(posedge clock); #1;
        access(1'b1, 1'b0, 28'h0000007, 128'd0, busy);
        $display("seq abort_write_readback busy=%0d readdata=%h", busy, mem_readdata);
        chk("abort_rb_busy", 128'(busy), 128'd5);
        chk("abort_rb_readdata", mem_readdata, 128'd0);
        @(posedge clock); #1;
        go_idle();
        @(posedge clock); #1;

        // Write-back then refill switched at the DONE edge.
        access(1'b0, 1'b1, 28'h0000009, C, busy);
        chk("b2b_write_busy", 128'(busy), 128'd5);
        @(posedge clock); #1;
        access(1'b1, 1'b0, 28'h0000004, 128'd0, busy);
        $display("seq b2b_read4 busy=%0d readdata=%h", busy, mem_readdata);
        chk("b2b_read_busy", 128'(busy), 128'd5);
        chk("b2b_read_readdata", mem_readdata, E);
        @(posedge clock); #1;
        access(1'b1, 1'b0, 28'h0000009, 128'd0, busy);
        $display("seq b2b_read9 busy=%0d readdata=%h", busy, mem_readdata);
        chk("b2b_read9_readdata", mem_readdata, C);
        chk("b2b_perr_sticky", {127'd0, protocol_error}, 128'd1);
        @(posedge clock); #1;
        go_idle();
        @(posedge clock); #1;

        // Reset in the middle of a write.
        mem_write = 1'b1; mem_address = 28'h000000B; mem_writedata = F;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        go_idle();
        #1;
        $display("seq reset_mid_busy busywait=%0b readdata=%h perr=%0b",
                 mem_busywait, mem_readdata, protocol_error);
        chk("rst_busywait", {127'd0, mem_busywait}, 128'd0);
        chk("rst_readdata", mem_readdata, 128'd0);
        chk("rst_perr", {127'd0, protocol_error}, 128'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        access(1'b1, 1'b0, 28'h000000B, 128'd0, busy);
        chk("rst_rb_busy", 128'(busy), 128'd5);
        chk("rst_rb_readdata", mem_readdata, 128'd0);
        @(posedge clock); #1;
        access(1'b1, 1'b0, 28'h0000003, 128'd0, busy);
        $display("seq reset_cleared_blk3 readdata=%h", mem_readdata);
        chk("rst_cleared_readdata", mem_readdata, 128'd0);
        chk("rst_cleared_perr", {127'd0, protocol_error}, 128'd0);
        @(posedge clock); #1;

        // Address changed during BUSY: latched address wins, error flagged.
        access(1'b0, 1'b1, 28'h0000005, G, busy);
        @(posedge clock); #1;
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 28'h0000005;
        @(posedge clock); @(posedge clock); #1;
        mem_address = 28'h0000006;
        busy = 0;
        do begin
            @(negedge clock);
            busy++;
        end while (mem_busywait && busy < 300);
        $display("seq addr_change readdata=%h perr=%0b", mem_readdata, protocol_error);
        chk("addrchg_timeout", 128'(busy < 300), 128'd1);
        chk("addrchg_readdata", mem_readdata, G);
        chk("addrchg_perr", {127'd0, protocol_error}, 128'd1);
        @(posedge clock); #1;
        go_idle();

        // Read and write together: no request, but an error.
        reset = 1'b1;
        #2 reset = 1'b0;
        @(posedge clock); #1;
        chk("both_pre_perr", {127'd0, protocol_error}, 128'd0);
        mem_read = 1'b1; mem_write = 1'b1; mem_address = 28'h0000005;
        #1 chk("both_busywait", {127'd0, mem_busywait}, 128'd0);
        @(posedge clock); #1;
        $display("seq read_and_write busywait=%0b perr=%0b", mem_busywait, protocol_error);
        chk("both_perr", {127'd0, protocol_error}, 128'd1);
        chk("both_busywait2", {127'd0, mem_busywait}, 128'd0);
        go_idle();
        @(posedge clock); #1;
        access(1'b1, 1'b0, 28'h0000005, 128'd0, busy);
        chk("both_no_advance_readdata", mem_readdata, 128'd0);
        go_idle();
        @(posedge clock); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
